goertzel_tone_detector: RTL and testbench
=========================================

Name: goertzel_tone_detector

Overview:
- Receive-side counterpart to the DDS tone generator: consumes 8-bit offset-binary audio samples from the ADC front end and detects a single target tone (default 660 Hz start tone at 10 kHz sample rate) with a Goertzel filter.
- Computes bin power once per block of N_SAMPLES samples and thresholds it with hit/miss hysteresis.
- Drives a debounced DETECTED flag to the robot control FSM.

Parameters:
- N_SAMPLES, 256, samples per Goertzel block; must be ≥ 8.
- COEFF, 29957, signed 16-bit Q2.14 value of 2·cos(2πk/N); k=17 for 660 Hz at 10 kHz.
- POWER_SHIFT, 16, right shift applied to the 48-bit power before output.
- THRESH, 500, POWER ≥ THRESH counts as a hit.
- HITS, 3, consecutive hit blocks needed to set DETECTED.
- MISSES, 2, consecutive miss blocks needed to clear DETECTED.

Ports:
- CLK  in  1  system clock, 25 MHz.
- RESET  in  1  synchronous, active-high.
- ENABLE  in  1  detector enable; low behaves as RESET, mirroring the generator's SW.
- SAMPLE_VALID  in  1  one-cycle strobe, SAMPLE valid.
- SAMPLE  in  8  unsigned offset-binary sample, 128 = midscale.
- POWER  out  32  last block power, unsigned.
- POWER_VALID  out  1  one-cycle pulse when POWER updates.
- DETECTED  out  1  debounced tone present.

Behaviour:
- Reset / ENABLE low (RESET has priority; both are equivalent):
  - All outputs 0.
  - s1, s2, sample counter, hit counter, miss counter and pipeline valids cleared.
  - Any in-flight power computation is discarded.
- Input conversion: x = SAMPLE − 128, as a 9-bit signed value.
- Accumulation, on each SAMPLE_VALID:
  - s = x + ((COEFF·s1) >>> 14) − s2, with a 40-bit product and arithmetic shift.
  - Result saturates to 24-bit signed ±(2^23−1).
  - Then s2 ← s1 and s1 ← s.
  - s1 and s2 are 24-bit signed.
- Block end:
  - On the SAMPLE_VALID with sample counter = N_SAMPLES−1, the new s and the old s1 are latched into snapshot registers (q1 = s, q2 = old s1).
  - In the same edge, s1, s2 and the counter are cleared. The next block starts with no sample lost.
- Power pipeline (sub-module), 4 stages on the snapshot:
  - P = q1² + q2² − ((COEFF·q1) >>> 14)·q2, using 48-bit signed arithmetic.
  - Negative P clamps to 0.
  - POWER = P >> POWER_SHIFT, saturated to 2^32−1.
- Latency: if the final sample is presented in cycle t, POWER and POWER_VALID are asserted in cycle t+4. POWER holds its value until the next update.
- Throughput: at most one block end per N_SAMPLES strobes. N_SAMPLES ≥ 8 guarantees the pipeline is idle at each block end. SAMPLE_VALID is accepted every cycle, no backpressure.
- Hysteresis FSM, states IDLE and TONE, evaluated on the POWER_VALID edge. DETECTED updates in cycle t+5.
  - IDLE, hit: hit_cnt += 1, miss_cnt = 0. When hit_cnt reaches HITS, go to TONE, set DETECTED = 1, hit_cnt = 0.
  - IDLE, miss: hit_cnt = 0.
  - TONE, miss: miss_cnt += 1, hit_cnt = 0. When miss_cnt reaches MISSES, go to IDLE, set DETECTED = 0, miss_cnt = 0.
  - TONE, hit: miss_cnt = 0.
  - Counter widths: clog2(HITS+1) and clog2(MISSES+1); they never exceed HITS / MISSES.
- Simultaneous events:
  - RESET or ENABLE low in the same cycle as SAMPLE_VALID: the reset wins and the sample is dropped.
  - SAMPLE_VALID during pipeline stages: the sample is accumulated normally.

Decomposition:
- Package goertzel_pkg holds:
  - COEFF_FRAC = 14, S_WIDTH = 24, PROD_WIDTH = 40, PWR_WIDTH = 48.
  - The saturation helper function.
  - The FSM state encoding (IDLE = 0, TONE = 1).
- Sub-module goertzel_power holds the 4-stage registered magnitude pipeline, with valid-in / valid-out and shared multipliers.
- Top level holds input conversion, accumulator, sample counter, snapshot and hysteresis FSM.

Test Plan:
- DC input (SAMPLE = 128) for 3 blocks → POWER = 0 on each of 3 POWER_VALID pulses; DETECTED stays 0.
- Tone at bin 17 (x = round(100·sin(2π·17·n/256)), with N_SAMPLES, POWER_SHIFT and all other parameters at their defaults) → POWER within 2500 ± 5%. POWER_VALID arrives exactly 4 cycles after the 256th strobe. DETECTED rises 1 cycle after the 3rd pulse.
- Amplitude-100 tone at bin 40 → every POWER < 50; DETECTED stays 0.
- With DETECTED = 1, apply 1 silent block, then tone, then 2 silent blocks → DETECTED stays 1 through the single miss. It falls 1 cycle after the 2nd consecutive miss pulse.
- RESET asserted after 100 samples of a block → all outputs 0 next cycle. No POWER_VALID until 256 further strobes. Repeat with ENABLE low for identical results.
- Back-to-back strobes every cycle across a block boundary, full-scale tone (0/255 extremes) → no lost sample; s1/s2 never saturate; POWER saturates at 2^32−1 only if P >> 16 exceeds it.

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared widths, saturation helper and detector state encoding for the
// Goertzel tone detector.
package goertzel_pkg;

  localparam int COEFF_FRAC = 14;
  localparam int S_WIDTH    = 24;
  localparam int PROD_WIDTH = 40;
  localparam int PWR_WIDTH  = 48;
  localparam int SUM_WIDTH  = PROD_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    TONE = 1'b1
  } state_e;

  // Clamp the accumulator sum to the symmetric range +/-(2^23-1).
  function automatic logic signed [S_WIDTH-1:0] sat_s(input logic signed [SUM_WIDTH-1:0] v);
    logic signed [SUM_WIDTH-1:0] lim;
    logic signed [SUM_WIDTH-1:0] neg_lim;
    lim     = {{(SUM_WIDTH-S_WIDTH+1){1'b0}}, {(S_WIDTH-1){1'b1}}};
    neg_lim = -lim;
    if (v > lim) begin
      return lim[S_WIDTH-1:0];
    end else if (v < neg_lim) begin
      return neg_lim[S_WIDTH-1:0];
    end
    return v[S_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/goertzel_power.sv
// Registered bin-power pipeline behind the block snapshot; two multipliers
// are reused across consecutive stages since at most one block is in flight.
module goertzel_power
  import goertzel_pkg::*;
#(
  parameter logic signed [15:0] COEFF       = 16'sd29957,
  parameter int                 POWER_SHIFT = 16
) (
  input  logic                      CLK,
  input  logic                      clr_i,
  input  logic                      valid_i,
  input  logic signed [S_WIDTH-1:0] q1_i,
  input  logic signed [S_WIDTH-1:0] q2_i,
  output logic [31:0]               power_o,
  output logic                      valid_o
);

  logic signed [PWR_WIDTH-1:0] a_lhs, a_rhs, b_lhs, b_rhs;
  logic signed [PWR_WIDTH-1:0] mul_a, mul_b, shifted;
  logic signed [PWR_WIDTH-1:0] sq1_q, cq1_q, p_q;
  logic                        v1_q, v2_q, valid_q;
  logic [31:0]                 power_q;

  // First use: q1^2 and COEFF*q1. Second use: q2^2 and (COEFF*q1>>>14)*q2.
  // The snapshot is held by the top level until the next block end.
  always_comb begin
    a_lhs = PWR_WIDTH'(q1_i);
    a_rhs = PWR_WIDTH'(q1_i);
    b_lhs = PWR_WIDTH'(COEFF);
    b_rhs = PWR_WIDTH'(q1_i);
    if (v1_q) begin
      a_lhs = PWR_WIDTH'(q2_i);
      a_rhs = PWR_WIDTH'(q2_i);
      b_lhs = cq1_q;
      b_rhs = PWR_WIDTH'(q2_i);
    end
  end

  assign mul_a   = a_lhs * a_rhs;
  assign mul_b   = b_lhs * b_rhs;
  assign shifted = p_q >>> POWER_SHIFT;

  always_ff @(posedge CLK) begin
    if (clr_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      sq1_q   <= '0;
      cq1_q   <= '0;
      p_q     <= '0;
      power_q <= '0;
    end else begin
      v1_q    <= valid_i;
      v2_q    <= v1_q;
      valid_q <= v2_q;
      if (valid_i) begin
        sq1_q <= mul_a;
        cq1_q <= mul_b >>> COEFF_FRAC;
      end
      if (v1_q) begin
        p_q <= sq1_q + mul_a - mul_b;
      end
      if (v2_q) begin
        if (p_q[PWR_WIDTH-1]) begin
          power_q <= '0;
        end else if (|shifted[PWR_WIDTH-1:32]) begin
          power_q <= '1;
        end else begin
          power_q <= shifted[31:0];
        end
      end
    end
  end

  assign power_o = power_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/goertzel_tone_detector.sv
// Goertzel single-bin tone detector: sample accumulator, block snapshot,
// power pipeline and hit/miss hysteresis driving DETECTED.
module goertzel_tone_detector
  import goertzel_pkg::*;
#(
  parameter int                 N_SAMPLES   = 256,
  parameter logic signed [15:0] COEFF       = 16'sd29957,
  parameter int                 POWER_SHIFT = 16,
  parameter logic [31:0]        THRESH      = 32'd500,
  parameter int                 HITS        = 3,
  parameter int                 MISSES      = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        SAMPLE_VALID,
  input  logic [7:0]  SAMPLE,
  output logic [31:0] POWER,
  output logic        POWER_VALID,
  output logic        DETECTED,
  output state_e      DBG_STATE
);

  localparam int CNT_W  = $clog2(N_SAMPLES);
  localparam int HIT_W  = $clog2(HITS + 1);
  localparam int MISS_W = $clog2(MISSES + 1);

  logic                         clr;
  logic signed [8:0]            x;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [SUM_WIDTH-1:0]  sum;
  logic signed [S_WIDTH-1:0]    s_new, s1_q, s2_q, q1_q, q2_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         last, snap_v_q, hit;
  state_e                       state_q, state_d;
  logic [HIT_W-1:0]             hit_cnt_q, hit_cnt_d;
  logic [MISS_W-1:0]            miss_cnt_q, miss_cnt_d;

  assign clr = RESET | ~ENABLE;

  // Offset binary to two's complement: flip the MSB, then sign-extend.
  assign x     = {{2{~SAMPLE[7]}}, SAMPLE[6:0]};
  assign prod  = PROD_WIDTH'(COEFF) * PROD_WIDTH'(s1_q);
  assign sum   = SUM_WIDTH'(x) + SUM_WIDTH'(prod >>> COEFF_FRAC) - SUM_WIDTH'(s2_q);
  assign s_new = sat_s(sum);
  assign last  = (cnt_q == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge CLK) begin
    if (clr) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cnt_q    <= '0;
      q1_q     <= '0;
      q2_q     <= '0;
      snap_v_q <= 1'b0;
    end else begin
      snap_v_q <= 1'b0;
      if (SAMPLE_VALID) begin
        if (last) begin
          q1_q     <= s_new;
          q2_q     <= s1_q;
          s1_q     <= '0;
          s2_q     <= '0;
          cnt_q    <= '0;
          snap_v_q <= 1'b1;
        end else begin
          s2_q  <= s1_q;
          s1_q  <= s_new;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  goertzel_power #(
    .COEFF       (COEFF),
    .POWER_SHIFT (POWER_SHIFT)
  ) u_power (
    .CLK     (CLK),
    .clr_i   (clr),
    .valid_i (snap_v_q),
    .q1_i    (q1_q),
    .q2_i    (q2_q),
    .power_o (POWER),
    .valid_o (POWER_VALID)
  );

  assign hit = (POWER >= THRESH);

  // Hysteresis only advances on a fresh block power.
  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (POWER_VALID) begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            miss_cnt_d = '0;
            if (hit_cnt_q == HIT_W'(HITS - 1)) begin
              state_d   = TONE;
              hit_cnt_d = '0;
            end else begin
              hit_cnt_d = hit_cnt_q + HIT_W'(1);
            end
          end else begin
            hit_cnt_d = '0;
          end
        end
        TONE: begin
          if (!hit) begin
            hit_cnt_d = '0;
            if (miss_cnt_q == MISS_W'(MISSES - 1)) begin
              state_d    = IDLE;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      state_q    <= IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign DETECTED  = (state_q == TONE);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Bench for goertzel_tone_detector: randomized sample blocks, a block-level
// Goertzel/hysteresis reference model and a queue-based output scoreboard.
module tb_goertzel_tone_detector;
  import goertzel_pkg::*;

  localparam int     N       = 256;
  localparam longint COEFF_L = 29957;
  localparam int     SHIFT   = 16;
  localparam longint THRESH  = 500;
  localparam int     HITS    = 3;
  localparam int     MISSES  = 2;
  localparam longint FULL    = 64'h0000_0000_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, SAMPLE_VALID;
  logic [7:0]  SAMPLE;
  logic [31:0] POWER;
  logic        POWER_VALID, DETECTED;
  state_e      dbg_state;

  goertzel_tone_detector dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE       (SAMPLE),
    .POWER        (POWER),
    .POWER_VALID  (POWER_VALID),
    .DETECTED     (DETECTED),
    .DBG_STATE    (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #20 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  longint      lo_q[$], hi_q[$];
  logic        det_q[$];
  int          blk_x[$];
  longint      rng_lo = 0, rng_hi = FULL;
  bit          det_m = 1'b0;
  int          streak = 0;
  logic        det_last = 1'b0;
  bit          det_pending = 1'b0;
  int          pv_count = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sat24(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388607) return -8388607;
    return v;
  endfunction

  // Whole-block Goertzel power straight from the arithmetic definition.
  function automatic longint block_power();
    longint s1 = 0, s2 = 0, s, p;
    foreach (blk_x[i]) begin
      s  = sat24(longint'(blk_x[i]) + ((COEFF_L * s1) >>> 14) - s2);
      s2 = s1;
      s1 = s;
    end
    p = s1 * s1 + s2 * s2 - (((COEFF_L * s1) >>> 14) * s2);
    if (p < 0) p = 0;
    p = p >>> SHIFT;
    if (p > FULL) p = FULL;
    return p;
  endfunction

  // Flag flips after a run of outcomes disagreeing with it: HITS to set, MISSES to clear.
  function automatic void hyst(input bit hit);
    if (hit != det_m) streak++;
    else streak = 0;
    if (!det_m && streak == HITS) begin
      det_m = 1'b1;
      streak = 0;
    end else if (det_m && streak == MISSES) begin
      det_m = 1'b0;
      streak = 0;
    end
  endfunction

  task automatic accept(input logic [7:0] v);
    longint p;
    blk_x.push_back(int'(v) - 128);
    if (blk_x.size() == N) begin
      p = block_power();
      exp_q.push_back(p[31:0]);
      exp_cyc_q.push_back(cyc + 4);
      lo_q.push_back(rng_lo);
      hi_q.push_back(rng_hi);
      hyst(p >= THRESH);
      det_q.push_back(det_m);
      blk_x.delete();
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [31:0] e;
    int          ec;
    longint      lo, hi;
    logic        d;
    if (det_pending) begin
      det_pending = 1'b0;
      if (det_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL detected_after_power: no expectation queued (cycle %0d)", cyc);
      end else begin
        d = det_q.pop_front();
        check("detected_after_power", longint'(DETECTED), longint'(d));
        det_last = d;
      end
    end
    if (POWER_VALID) begin
      pv_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_power_valid: got POWER_VALID=1 required 0 (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        lo = lo_q.pop_front();
        hi = hi_q.pop_front();
        check("power", longint'(POWER), longint'(e));
        check("power_latency_cycle", longint'(cyc), longint'(ec));
        if (lo != 0 || hi != FULL) check_range("power_range", longint'(POWER), lo, hi);
        check("detected_hold_at_pulse", longint'(DETECTED), longint'(det_last));
        det_pending = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] tone_byte(input int amp, input int bin, input int n, input int noise);
    real ph;
    int  xi;
    ph = 2.0 * 3.141592653589793 * real'(bin) * real'(n) / real'(N);
    xi = int'(real'(amp) * $sin(ph));
    if (noise > 0) xi = xi + int'($urandom_range(0, 2 * noise)) - noise;
    if (xi < -128) xi = -128;
    if (xi > 127) xi = 127;
    return 8'(xi + 128);
  endfunction

  task automatic send(input logic [7:0] v, input int gap);
    @(negedge CLK);
    SAMPLE_VALID = 1'b1;
    SAMPLE       = v;
    accept(v);
    repeat (gap) begin
      @(negedge CLK);
      SAMPLE_VALID = 1'b0;
    end
  endtask

  task automatic send_samples(input int count, input int amp, input int bin, input int n0,
                              input int max_gap, input int noise);
    for (int n = 0; n < count; n++)
      send(tone_byte(amp, bin, n0 + n, noise), int'($urandom_range(0, max_gap)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      SAMPLE_VALID = 1'b0;
    end
  endtask

  task automatic set_range(input longint lo, input longint hi);
    rng_lo = lo;
    rng_hi = hi;
  endtask

  // Reset (or disable) mid-block with a coincident strobe that must be dropped.
  task automatic reset_mid(input bit use_enable);
    int mark;
    @(negedge CLK);
    if (use_enable) ENABLE = 1'b0;
    else RESET = 1'b1;
    SAMPLE_VALID = 1'b1;
    SAMPLE       = 8'($urandom_range(0, 255));
    blk_x.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    lo_q.delete();
    hi_q.delete();
    det_q.delete();
    det_m    = 1'b0;
    streak   = 0;
    det_last = 1'b0;
    @(negedge CLK);
    RESET        = 1'b0;
    ENABLE       = 1'b1;
    SAMPLE_VALID = 1'b0;
    check(use_enable ? "enable_low_power" : "reset_power", longint'(POWER), 0);
    check(use_enable ? "enable_low_power_valid" : "reset_power_valid", longint'(POWER_VALID), 0);
    check(use_enable ? "enable_low_detected" : "reset_detected", longint'(DETECTED), 0);
    check(use_enable ? "enable_low_state" : "reset_state", longint'(dbg_state), longint'(IDLE));
    mark = pv_count;
    set_range(0, FULL);
    send_samples(N - 1, 100, 17, 0, 1, 0);
    idle(8);
    check(use_enable ? "enable_low_no_early_power" : "reset_no_early_power", longint'(pv_count), longint'(mark));
    send(tone_byte(100, 17, N - 1, 0), 0);
    idle(8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET        = 1'b1;
    ENABLE       = 1'b1;
    SAMPLE_VALID = 1'b0;
    SAMPLE       = 8'd128;
    repeat (3) @(negedge CLK);
    check("init_power", longint'(POWER), 0);
    check("init_power_valid", longint'(POWER_VALID), 0);
    check("init_detected", longint'(DETECTED), 0);
    check("init_state", longint'(dbg_state), longint'(IDLE));
    RESET = 1'b0;

    set_range(0, 0);            // DC input
    for (int b = 0; b < 3; b++) send_samples(N, 0, 17, 0, 2, 0);
    set_range(0, 49);           // off-bin tone
    for (int b = 0; b < 2; b++) send_samples(N, 100, 40, 0, 1, 0);
    set_range(2375, 2625);      // on-bin tone, strobes back to back
    for (int b = 0; b < 3; b++) send_samples(N, 100, 17, 0, 0, 0);

    set_range(0, 0);            // single miss, hit, then two misses
    send_samples(N, 0, 17, 0, 1, 0);
    set_range(2375, 2625);
    send_samples(N, 100, 17, 0, 1, 0);
    set_range(0, 0);
    for (int b = 0; b < 2; b++) send_samples(N, 0, 17, 0, 1, 0);

    set_range(0, FULL);         // noisy tone, random amplitude and gaps
    for (int b = 0; b < 3; b++)
      send_samples(N, int'($urandom_range(90, 120)), 17, 0, 2, 3);

    send_samples(100, 100, 17, 0, 1, 0);
    reset_mid(1'b0);
    send_samples(2 * N, 100, 17, 0, 1, 0);
    send_samples(100, 100, 17, 0, 1, 0);
    reset_mid(1'b1);

    set_range(0, FULL);         // full-scale tone across a boundary
    for (int b = 0; b < 2; b++) send_samples(N, 128, 17, 0, 0, 0);
    for (int b = 0; b < 4; b++)
      send_samples(N, int'($urandom_range(0, 127)),
                   ($urandom_range(0, 1) == 1) ? 17 : int'($urandom_range(0, 127)),
                   0, 3, int'($urandom_range(0, 8)));

    idle(12);
    check("pending_expectations", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
